fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 29 ++
 rtl/fetch_bht.sv | 50 +++++
 rtl/fetch_unit.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared instruction-set constants and helpers for the fetch unit.
//   INST_W             : instruction width
//   OPC_JAL/JALR/B     : RV32 opcodes the predictor recognises
//   fetch_state_e      : refill FSM states
//   imm_j / imm_b      : sign-extended 32-bit J/B immediates
package fetch_unit_pkg;

    localparam int unsigned INST_W = 32;

    localparam logic [6:0] OPC_JAL  = 7'b1101111;
    localparam logic [6:0] OPC_JALR = 7'b1100111;
    localparam logic [6:0] OPC_B    = 7'b1100011;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FETCH = 1'b1
    } fetch_state_e;

    // J-type offset: imm[20|10:1|11|19:12] in inst[31:12]
    function automatic logic [31:0] imm_j(input logic [INST_W-1:0] i);
        return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endfunction

    // B-type offset: imm[12|10:5] in inst[31:25], imm[4:1|11] in inst[11:7]
    function automatic logic [31:0] imm_b(input logic [INST_W-1:0] i);
        return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_bht.sv
// Branch history table of 2-bit saturating counters.
//   rd_pc    -> rd_cnt_c : combinational counter read (pre-update value)
//   upd/upd_j/upd_pc     : committed-branch update, taken increments,
//                          not-taken decrements, both saturating
//   rdy=0 freezes the table; rst (active-low, async) clears to 0.
module fetch_bht
    import fetch_unit_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned BHT_NUM = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic [ADDR_W-1:0] rd_pc,
    output logic [1:0]        rd_cnt_c,
    input  logic              upd,
    input  logic              upd_j,
    input  logic [ADDR_W-1:0] upd_pc
);

    localparam int unsigned BHT_W = $clog2(BHT_NUM);

    logic [1:0]       cnt_q [BHT_NUM];
    logic [BHT_W-1:0] rd_idx;
    logic [BHT_W-1:0] upd_idx;
    logic             unused_pc_bits;

    assign rd_idx   = rd_pc[2 +: BHT_W];
    assign upd_idx  = upd_pc[2 +: BHT_W];
    assign rd_cnt_c = cnt_q[rd_idx];

    // Only the word-index bits select a counter.
    assign unused_pc_bits = ^{rd_pc[ADDR_W-1:BHT_W+2], rd_pc[1:0],
                              upd_pc[ADDR_W-1:BHT_W+2], upd_pc[1:0]};

    // Saturating counter update; a same-cycle read still sees the old value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(BHT_NUM); i++) cnt_q[i] <= 2'd0;
        end else if (rdy && upd) begin
            if (upd_j) begin
                if (cnt_q[upd_idx] != 2'd3) cnt_q[upd_idx] <= cnt_q[upd_idx] + 2'd1;
            end else begin
                if (cnt_q[upd_idx] != 2'd0) cnt_q[upd_idx] <= cnt_q[upd_idx] - 2'd1;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: direct-mapped I-cache, line refill FSM, static JAL
// prediction and BHT-based conditional branch prediction.
//   clk, rst (async active-low), rdy (global enable)
//   rollback/rollback_pc     : redirect from the RoB
//   rs_full/lsb_full/rob_full: downstream back-pressure
//   mem_en/mem_addr          : line refill request (held during refill)
//   mem_done/mem_data        : refill response
//   inst_done/inst/inst_pc/inst_pre_j : one-cycle issued instruction
//   br_upd/br_upd_j/br_upd_pc: committed branch outcome
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned LINE_NUM   = 16,
    parameter int unsigned LINE_INSTS = 16,
    parameter int unsigned BHT_NUM    = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rdy,
    input  logic                         rollback,
    input  logic [ADDR_W-1:0]            rollback_pc,
    input  logic                         rs_full,
    input  logic                         lsb_full,
    input  logic                         rob_full,
    output logic                         mem_en,
    output logic [ADDR_W-1:0]            mem_addr,
    input  logic                         mem_done,
    input  logic [INST_W*LINE_INSTS-1:0] mem_data,
    output logic                         inst_done,
    output logic [INST_W-1:0]            inst,
    output logic [ADDR_W-1:0]            inst_pc,
    output logic                         inst_pre_j,
    input  logic                         br_upd,
    input  logic                         br_upd_j,
    input  logic [ADDR_W-1:0]            br_upd_pc
);

    localparam int unsigned WORD_W = $clog2(LINE_INSTS);
    localparam int unsigned OFF_W  = WORD_W + 2;
    localparam int unsigned IDX_W  = $clog2(LINE_NUM);
    localparam int unsigned TAG_W  = ADDR_W - OFF_W - IDX_W;
    localparam int unsigned LINE_W = INST_W * LINE_INSTS;

    logic [ADDR_W-1:0]   pc;
    logic [LINE_NUM-1:0] valid_q;
    logic [TAG_W-1:0]    tag_q  [LINE_NUM];
    logic [LINE_W-1:0]   data_q [LINE_NUM];

    fetch_state_e        state_q;
    fetch_state_e        state_d;
    logic                mem_en_d;
    logic [ADDR_W-1:0]   mem_addr_d;
    logic                fill_c;

    logic [IDX_W-1:0]    pc_idx;
    logic [TAG_W-1:0]    pc_tag;
    logic [WORD_W-1:0]   pc_word;
    logic                hit_c;
    logic [LINE_W-1:0]   line_c;
    logic [INST_W-1:0]   cur_inst_c;
    logic [1:0]          bht_cnt_c;
    logic                pred_j_c;
    logic [ADDR_W-1:0]   pred_pc_c;
    logic                issue_c;

    logic [IDX_W-1:0]    fill_idx;
    logic [TAG_W-1:0]    fill_tag;
    logic                unused_addr_bits;

    // Cache lookup for the current PC.
    assign pc_idx     = pc[OFF_W +: IDX_W];
    assign pc_tag     = pc[ADDR_W-1 -: TAG_W];
    assign pc_word    = pc[2 +: WORD_W];
    assign hit_c      = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
    assign line_c     = data_q[pc_idx];
    assign cur_inst_c = line_c[pc_word*INST_W +: INST_W];

    // Refill always lands where its own request pointed, regardless of pc.
    assign fill_idx         = mem_addr[OFF_W +: IDX_W];
    assign fill_tag         = mem_addr[ADDR_W-1 -: TAG_W];
    assign unused_addr_bits = ^mem_addr[OFF_W-1:0];

    assign issue_c = hit_c && !rs_full && !lsb_full && !rob_full && !rollback;

    fetch_bht #(
        .ADDR_W  (ADDR_W),
        .BHT_NUM (BHT_NUM)
    ) u_bht (
        .clk      (clk),
        .rst      (rst),
        .rdy      (rdy),
        .rd_pc    (pc),
        .rd_cnt_c (bht_cnt_c),
        .upd      (br_upd),
        .upd_j    (br_upd_j),
        .upd_pc   (br_upd_pc)
    );

    // Next-PC prediction; JALR and everything else fall through to pc+4.
    always_comb begin
        pred_j_c  = 1'b0;
        pred_pc_c = pc + ADDR_W'(4);
        case (cur_inst_c[6:0])
            OPC_JAL: begin
                pred_j_c  = 1'b1;
                pred_pc_c = pc + ADDR_W'($signed(imm_j(cur_inst_c)));
            end
            OPC_B: begin
                if (bht_cnt_c[1]) begin
                    pred_j_c  = 1'b1;
                    pred_pc_c = pc + ADDR_W'($signed(imm_b(cur_inst_c)));
                end
            end
            OPC_JALR: begin
                pred_j_c = 1'b0;
            end
            default: begin
                pred_j_c = 1'b0;
            end
        endcase
    end

    // Refill FSM next state; request is held until the line returns.
    always_comb begin
        state_d    = state_q;
        mem_en_d   = mem_en;
        mem_addr_d = mem_addr;
        fill_c     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!hit_c) begin
                    mem_en_d   = 1'b1;
                    mem_addr_d = {pc[ADDR_W-1:OFF_W], OFF_W'(0)};
                    state_d    = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (mem_done) begin
                    fill_c   = 1'b1;
                    mem_en_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Refill FSM state and request registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            mem_en   <= 1'b0;
            mem_addr <= '0;
        end else if (rdy) begin
            state_q  <= state_d;
            mem_en   <= mem_en_d;
            mem_addr <= mem_addr_d;
        end
    end

    // Valid bits; the new line becomes a hit the cycle after the write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
        end else if (rdy && fill_c) begin
            valid_q[fill_idx] <= 1'b1;
        end
    end

    // Tag and data arrays need no reset: valid bits guard them.
    always_ff @(posedge clk) begin
        if (rdy && fill_c) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= mem_data;
        end
    end

    // PC and issue registers; rollback wins over issue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc         <= '0;
            inst_done  <= 1'b0;
            inst       <= '0;
            inst_pc    <= '0;
            inst_pre_j <= 1'b0;
        end else if (rdy) begin
            if (rollback) begin
                pc        <= rollback_pc;
                inst_done <= 1'b0;
            end else if (issue_c) begin
                inst_done  <= 1'b1;
                inst       <= cur_inst_c;
                inst_pc    <= pc;
                inst_pre_j <= pred_j_c;
                pc         <= pred_pc_c;
            end else begin
                inst_done <= 1'b0;
            end
        end
    end

endmodule
